tuner_lock_phy: RTL and testbench
=================================

TUNER_LOCK_PHY -- requirements
Module: tuner_lock_phy

Interface
REQ-001 SHALL have parameter DAC_WIDTH, default 8, ring tune code width.
REQ-002 SHALL have parameter ADC_WIDTH, default 8, power sample width.
REQ-003 SHALL have parameter NUM_TARGET, default 4, peak table depth.
REQ-004 SHALL have parameter LOCK_CNT, default 4, consecutive centre-wins needed to declare lock.
REQ-005 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port i_rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_lock_en, input, 1, level enable; low forces IDLE.
REQ-008 SHALL have ports i_peaks_val (input, 1) and o_peaks_rdy (output, 1), the peak-table handshake from the search stage.
REQ-009 SHALL have ports i_ring_tune_peaks[NUM_TARGET] (input, DAC_WIDTH), i_pwr_peaks[NUM_TARGET] (input, ADC_WIDTH) and i_peaks_cnt (input, $clog2(NUM_TARGET)), index of the highest valid entry.
REQ-010 SHALL have ports i_sel_mode (input, 1; 0=max power, 1=index) and i_sel_idx (input, $clog2(NUM_TARGET)).
REQ-011 SHALL have ports o_ring_tune_val (output, 1), i_ring_tune_rdy (input, 1) and o_ring_tune (output, DAC_WIDTH), the tune request to the arbiter.
REQ-012 SHALL have ports i_pwr_val (input, 1) and i_pwr (input, ADC_WIDTH), the settled drop-power sample.
REQ-013 SHALL have ports o_locked (1), o_lock_code (DAC_WIDTH), o_fail (1) and o_mon_state (tuner_lock_state_e), all outputs.

Function
REQ-014 SHALL implement states IDLE, SELECT, APPLY_C, MEAS_C, APPLY_U, MEAS_U, APPLY_D, MEAS_D, DECIDE, FAIL.
REQ-015 SHALL drive o_peaks_rdy=1 only in IDLE with i_lock_en=1; a table transfer completes on i_peaks_val&&o_peaks_rdy and moves the FSM to SELECT.
REQ-016 SHALL, in SELECT (1 cycle), pick the highest-power entry with index<=i_peaks_cnt when i_sel_mode=0 (ties go to the lowest index), or entry i_sel_idx when i_sel_mode=1; the chosen code becomes centre c and its power becomes pref.
REQ-017 SHALL go to FAIL when the selected pwr equals 0, or when i_sel_mode=1 and i_sel_idx>i_peaks_cnt; otherwise it SHALL go to APPLY_C.
REQ-018 SHALL, in APPLY_x, hold o_ring_tune_val=1 with o_ring_tune equal to c, c+1 or c-1 until i_ring_tune_rdy; o_ring_tune SHALL stay stable while the request is unacknowledged.
REQ-019 SHALL, in MEAS_x, capture i_pwr on the first i_pwr_val cycle and ignore i_pwr_val in all other states.
REQ-020 SHALL skip APPLY_U/MEAS_U when c is the all-ones code and skip APPLY_D/MEAS_D when c=0, treating a skipped sample as 0.
REQ-021 SHALL, in DECIDE, move c to the maximum-power point with tie priority centre > up > down, then return to APPLY_C.
REQ-022 SHALL increment the stable counter when the centre wins and clear it otherwise; the counter SHALL saturate at LOCK_CNT.
REQ-023 SHALL set o_locked when the counter reaches LOCK_CNT and clear it when the counter clears.
REQ-024 SHALL drive o_lock_code with the current c, and tracking SHALL continue while locked.
REQ-025 SHALL, when i_lock_en falls in any state, go to IDLE on the next edge, deassert o_ring_tune_val and clear o_locked, o_fail and the counter.
REQ-026 SHALL hold o_fail=1 in FAIL; FAIL exits only to IDLE, via i_lock_en low.
REQ-027 SHALL treat all power comparisons as unsigned ADC_WIDTH and all code arithmetic as unsigned DAC_WIDTH without wrap.

Reset
REQ-028 SHALL, while i_rst=0 and independent of i_clk, force state IDLE, c=0, pref=0, counter=0, o_peaks_rdy=0, o_ring_tune_val=0, o_ring_tune=0, o_locked=0, o_lock_code=0 and o_fail=0.
REQ-029 SHALL, on reset mid-handshake, drop any pending request with no completion.

Configuration
REQ-030 SHALL, with TUNER_LOCK_LOSS_DETECT_EN defined, go to FAIL and clear o_locked when the MEAS_C sample is below pref>>1 while o_locked=1.
REQ-031 SHALL, without TUNER_LOCK_LOSS_DETECT_EN, omit the loss check so that only tie/centre logic applies.

Structure
REQ-032 SHALL define tuner_lock_state_e in tuner_phy_pkg.
REQ-033 SHALL place the combinational peak selector in sub-module tuner_lock_peak_sel.

Verification
REQ-034 SHALL cover: pwr_peaks {10,40,30,0}, cnt=2, mode 0 -> selects index 1, first o_ring_tune equals its code.
REQ-035 SHALL cover: mode 1, idx=3, cnt=2 -> FAIL, o_fail=1, no tune request issued.
REQ-036 SHALL cover: c=100, samples C=50, U=60, D=40 -> c=101; then centre wins 4 times -> o_locked=1, o_lock_code=101.
REQ-037 SHALL cover: c=0, C=20, U=10 -> no c-1 request, c remains 0.
REQ-038 SHALL cover: i_ring_tune_rdy held low 10 cycles -> o_ring_tune stable, no state advance; then i_lock_en=0 -> IDLE next edge.
REQ-039 SHALL cover: with TUNER_LOCK_LOSS_DETECT_EN, locked at pref=80 and MEAS_C sample 39 -> FAIL, o_locked=0.

Source files
------------

// File: rtl/tuner_phy_pkg.sv
// rtl/tuner_phy_pkg.sv - shared state encoding for the tuner lock PHY
package tuner_phy_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      SELECT  = 4'd1,
      APPLY_C = 4'd2,
      MEAS_C  = 4'd3,
      APPLY_U = 4'd4,
      MEAS_U  = 4'd5,
      APPLY_D = 4'd6,
      MEAS_D  = 4'd7,
      DECIDE  = 4'd8,
      FAIL    = 4'd9
   } tuner_lock_state_e;

   function automatic logic is_apply(input tuner_lock_state_e s);
      return (s == APPLY_C) || (s == APPLY_U) || (s == APPLY_D);
   endfunction

endpackage

// File: rtl/tuner_lock_peak_sel.sv
// rtl/tuner_lock_peak_sel.sv - combinational peak-table entry selector
// Ports:
//   i_tune[]  / i_pwr[] : captured peak table (codes / powers)
//   i_cnt               : index of highest valid entry
//   i_mode, i_idx       : 0 = highest power (lowest index on ties), 1 = entry i_idx
//   o_code, o_pwr       : chosen entry
//   o_idx_bad           : index mode asked for an entry beyond i_cnt
module tuner_lock_peak_sel #(
   parameter int DAC_WIDTH  = 8,
   parameter int ADC_WIDTH  = 8,
   parameter int NUM_TARGET = 4
) (
   input  logic [DAC_WIDTH-1:0]          i_tune [NUM_TARGET],
   input  logic [ADC_WIDTH-1:0]          i_pwr  [NUM_TARGET],
   input  logic [$clog2(NUM_TARGET)-1:0] i_cnt,
   input  logic                          i_mode,
   input  logic [$clog2(NUM_TARGET)-1:0] i_idx,
   output logic [DAC_WIDTH-1:0]          o_code,
   output logic [ADC_WIDTH-1:0]          o_pwr,
   output logic                          o_idx_bad
);

   logic [DAC_WIDTH-1:0] best_code;
   logic [ADC_WIDTH-1:0] best_pwr;

   always_comb begin
      best_code = i_tune[0];
      best_pwr  = i_pwr[0];
      // strict greater-than keeps the lowest index on ties
      for (int i = 1; i < NUM_TARGET; i++) begin
         if ((i <= int'(i_cnt)) && (i_pwr[i] > best_pwr)) begin
            best_code = i_tune[i];
            best_pwr  = i_pwr[i];
         end
      end

      if (i_mode) begin
         o_code    = i_tune[i_idx];
         o_pwr     = i_pwr[i_idx];
         o_idx_bad = (i_idx > i_cnt);
      end else begin
         o_code    = best_code;
         o_pwr     = best_pwr;
         o_idx_bad = 1'b0;
      end
   end

endmodule

// File: rtl/tuner_lock_phy.sv
// rtl/tuner_lock_phy.sv - ring tuner centre/up/down dither lock engine
// Optional feature macro: TUNER_LOCK_LOSS_DETECT_EN (lock-loss check in MEAS_C).
// Ports:
//   i_clk, i_rst (async active-low)   clock / reset
//   i_lock_en                          level enable, low returns to IDLE
//   i_peaks_val / o_peaks_rdy          peak table handshake, table on i_ring_tune_peaks,
//                                      i_pwr_peaks, i_peaks_cnt, i_sel_mode, i_sel_idx
//   o_ring_tune_val / i_ring_tune_rdy  tune request, code on o_ring_tune
//   i_pwr_val / i_pwr                  settled drop-power sample
//   o_locked, o_lock_code, o_fail      status; o_mon_state current FSM state
module tuner_lock_phy
   import tuner_phy_pkg::*;
#(
   parameter int DAC_WIDTH  = 8,
   parameter int ADC_WIDTH  = 8,
   parameter int NUM_TARGET = 4,
   parameter int LOCK_CNT   = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_lock_en,
   input  logic                          i_peaks_val,
   output logic                          o_peaks_rdy,
   input  logic [DAC_WIDTH-1:0]          i_ring_tune_peaks [NUM_TARGET],
   input  logic [ADC_WIDTH-1:0]          i_pwr_peaks [NUM_TARGET],
   input  logic [$clog2(NUM_TARGET)-1:0] i_peaks_cnt,
   input  logic                          i_sel_mode,
   input  logic [$clog2(NUM_TARGET)-1:0] i_sel_idx,
   output logic                          o_ring_tune_val,
   input  logic                          i_ring_tune_rdy,
   output logic [DAC_WIDTH-1:0]          o_ring_tune,
   input  logic                          i_pwr_val,
   input  logic [ADC_WIDTH-1:0]          i_pwr,
   output logic                          o_locked,
   output logic [DAC_WIDTH-1:0]          o_lock_code,
   output logic                          o_fail,
   output tuner_lock_state_e             o_mon_state
);

   localparam int IW = $clog2(NUM_TARGET);
   localparam int SW = $clog2(LOCK_CNT + 1);
   localparam logic [SW-1:0]        LOCK_MAX = SW'(LOCK_CNT);
   localparam logic [DAC_WIDTH-1:0] CODE_MAX = '1;

   tuner_lock_state_e state_q, state_d;
   logic [DAC_WIDTH-1:0] c_q, c_d;
   logic [SW-1:0]        stab_q, stab_d;
   logic                 locked_q, locked_d;
   logic [ADC_WIDTH-1:0] pc_q, pc_d, pu_q, pu_d, pd_q, pd_d;
`ifdef TUNER_LOCK_LOSS_DETECT_EN
   // reference power is only consumed by the lock-loss check
   logic [ADC_WIDTH-1:0] pref_q, pref_d;
`endif

   // peak table is captured on the handshake so the search stage may move on
   logic [DAC_WIDTH-1:0] tab_tune_q [NUM_TARGET];
   logic [DAC_WIDTH-1:0] tab_tune_d [NUM_TARGET];
   logic [ADC_WIDTH-1:0] tab_pwr_q  [NUM_TARGET];
   logic [ADC_WIDTH-1:0] tab_pwr_d  [NUM_TARGET];
   logic [IW-1:0]        tab_cnt_q, tab_cnt_d, tab_idx_q, tab_idx_d;
   logic                 tab_mode_q, tab_mode_d;

   logic [DAC_WIDTH-1:0] sel_code;
   logic [ADC_WIDTH-1:0] sel_pwr;
   logic                 sel_idx_bad;
   logic                 loss_det;

   tuner_lock_peak_sel #(
      .DAC_WIDTH (DAC_WIDTH),
      .ADC_WIDTH (ADC_WIDTH),
      .NUM_TARGET(NUM_TARGET)
   ) u_peak_sel (
      .i_tune   (tab_tune_q),
      .i_pwr    (tab_pwr_q),
      .i_cnt    (tab_cnt_q),
      .i_mode   (tab_mode_q),
      .i_idx    (tab_idx_q),
      .o_code   (sel_code),
      .o_pwr    (sel_pwr),
      .o_idx_bad(sel_idx_bad)
   );

   always_comb begin
`ifdef TUNER_LOCK_LOSS_DETECT_EN
      loss_det = locked_q && (i_pwr < (pref_q >> 1));
`else
      loss_det = 1'b0;
`endif
   end

   always_comb begin
      state_d    = state_q;
      c_d        = c_q;
      stab_d     = stab_q;
      locked_d   = locked_q;
      pc_d       = pc_q;
      pu_d       = pu_q;
      pd_d       = pd_q;
`ifdef TUNER_LOCK_LOSS_DETECT_EN
      pref_d     = pref_q;
`endif
      tab_tune_d = tab_tune_q;
      tab_pwr_d  = tab_pwr_q;
      tab_cnt_d  = tab_cnt_q;
      tab_idx_d  = tab_idx_q;
      tab_mode_d = tab_mode_q;

      if (!i_lock_en) begin
         state_d  = IDLE;
         stab_d   = '0;
         locked_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_peaks_val) begin
                  tab_tune_d = i_ring_tune_peaks;
                  tab_pwr_d  = i_pwr_peaks;
                  tab_cnt_d  = i_peaks_cnt;
                  tab_idx_d  = i_sel_idx;
                  tab_mode_d = i_sel_mode;
                  state_d    = SELECT;
               end
            end
            SELECT: begin
               if (sel_idx_bad || (sel_pwr == '0)) begin
                  state_d = FAIL;
               end else begin
                  c_d     = sel_code;
`ifdef TUNER_LOCK_LOSS_DETECT_EN
                  pref_d  = sel_pwr;
`endif
                  state_d = APPLY_C;
               end
            end
            APPLY_C: if (i_ring_tune_rdy) state_d = MEAS_C;
            MEAS_C: begin
               if (i_pwr_val) begin
                  pc_d = i_pwr;
                  if (loss_det) begin
                     state_d  = FAIL;
                     locked_d = 1'b0;
                     stab_d   = '0;
                  end else if (c_q != CODE_MAX) begin
                     state_d = APPLY_U;
                  end else begin
                     pu_d    = '0;
                     state_d = APPLY_D;
                  end
               end
            end
            APPLY_U: if (i_ring_tune_rdy) state_d = MEAS_U;
            MEAS_U: begin
               if (i_pwr_val) begin
                  pu_d = i_pwr;
                  if (c_q != '0) begin
                     state_d = APPLY_D;
                  end else begin
                     pd_d    = '0;
                     state_d = DECIDE;
                  end
               end
            end
            APPLY_D: if (i_ring_tune_rdy) state_d = MEAS_D;
            MEAS_D: begin
               if (i_pwr_val) begin
                  pd_d    = i_pwr;
                  state_d = DECIDE;
               end
            end
            DECIDE: begin
               // a skipped side reads 0 and so can never beat the centre
               // strictly, which keeps c from wrapping at either end
               if ((pc_q >= pu_q) && (pc_q >= pd_q)) begin
                  stab_d   = (stab_q == LOCK_MAX) ? stab_q : stab_q + 1'b1;
                  locked_d = (stab_d == LOCK_MAX);
               end else begin
                  c_d      = (pu_q >= pd_q) ? c_q + 1'b1 : c_q - 1'b1;
                  stab_d   = '0;
                  locked_d = 1'b0;
               end
               state_d = APPLY_C;
            end
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= IDLE;
         c_q        <= '0;
         stab_q     <= '0;
         locked_q   <= 1'b0;
         pc_q       <= '0;
         pu_q       <= '0;
         pd_q       <= '0;
`ifdef TUNER_LOCK_LOSS_DETECT_EN
         pref_q     <= '0;
`endif
         tab_tune_q <= '{default: '0};
         tab_pwr_q  <= '{default: '0};
         tab_cnt_q  <= '0;
         tab_idx_q  <= '0;
         tab_mode_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         c_q        <= c_d;
         stab_q     <= stab_d;
         locked_q   <= locked_d;
         pc_q       <= pc_d;
         pu_q       <= pu_d;
         pd_q       <= pd_d;
`ifdef TUNER_LOCK_LOSS_DETECT_EN
         pref_q     <= pref_d;
`endif
         tab_tune_q <= tab_tune_d;
         tab_pwr_q  <= tab_pwr_d;
         tab_cnt_q  <= tab_cnt_d;
         tab_idx_q  <= tab_idx_d;
         tab_mode_q <= tab_mode_d;
      end
   end

   // ready is gated by reset so it is low while reset is held
   assign o_peaks_rdy     = i_rst && (state_q == IDLE) && i_lock_en;
   assign o_ring_tune_val = is_apply(state_q);
   // c only changes in DECIDE/SELECT, so the code is stable during APPLY_x
   assign o_ring_tune     = (state_q == APPLY_U) ? c_q + 1'b1 :
                            (state_q == APPLY_D) ? c_q - 1'b1 : c_q;
   assign o_locked        = locked_q;
   assign o_lock_code     = c_q;
   assign o_fail          = (state_q == FAIL);
   assign o_mon_state     = state_q;

endmodule

// File: tb/tb_tuner_lock_phy.sv
// tb/tb_tuner_lock_phy.sv - directed self-checking bench for tuner_lock_phy
module tb_tuner_lock_phy;
   import tuner_phy_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic       i_lock_en = 1'b0;
   logic       i_peaks_val = 1'b0;
   logic       o_peaks_rdy;
   logic [7:0] tune_pk [4];
   logic [7:0] pwr_pk  [4];
   logic [1:0] i_peaks_cnt = 2'd0;
   logic       i_sel_mode = 1'b0;
   logic [1:0] i_sel_idx = 2'd0;
   logic       o_ring_tune_val;
   logic       i_ring_tune_rdy = 1'b0;
   logic [7:0] o_ring_tune;
   logic       i_pwr_val = 1'b0;
   logic [7:0] i_pwr = 8'd0;
   logic       o_locked;
   logic [7:0] o_lock_code;
   logic       o_fail;
   tuner_lock_state_e o_mon_state;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   tuner_lock_phy dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_lock_en        (i_lock_en),
      .i_peaks_val      (i_peaks_val),
      .o_peaks_rdy      (o_peaks_rdy),
      .i_ring_tune_peaks(tune_pk),
      .i_pwr_peaks      (pwr_pk),
      .i_peaks_cnt      (i_peaks_cnt),
      .i_sel_mode       (i_sel_mode),
      .i_sel_idx        (i_sel_idx),
      .o_ring_tune_val  (o_ring_tune_val),
      .i_ring_tune_rdy  (i_ring_tune_rdy),
      .o_ring_tune      (o_ring_tune),
      .i_pwr_val        (i_pwr_val),
      .i_pwr            (i_pwr),
      .o_locked         (o_locked),
      .o_lock_code      (o_lock_code),
      .o_fail           (o_fail),
      .o_mon_state      (o_mon_state)
   );

   task automatic do_reset;
      i_rst = 1'b0; i_lock_en = 1'b0; i_peaks_val = 1'b0;
      i_ring_tune_rdy = 1'b0; i_pwr_val = 1'b0; i_pwr = 8'd0;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
   endtask

   task automatic send_table(input logic [1:0] cnt, input logic mode, input logic [1:0] idx,
                             output bit ok);
      i_peaks_cnt = cnt; i_sel_mode = mode; i_sel_idx = idx;
      i_lock_en = 1'b1; i_peaks_val = 1'b1;
      #1;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (o_peaks_rdy === 1'b1) begin
            ok = 1'b1;
            @(negedge i_clk);
            break;
         end
         @(negedge i_clk);
      end
      i_peaks_val = 1'b0;
   endtask

   task automatic wait_req(output logic [7:0] code, output bit ok);
      ok = 1'b0; code = 8'd0;
      for (int k = 0; k < 40; k++) begin
         if (o_ring_tune_val === 1'b1) begin
            code = o_ring_tune; ok = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
   endtask

   task automatic ack;
      i_ring_tune_rdy = 1'b1;
      @(negedge i_clk);
      i_ring_tune_rdy = 1'b0;
   endtask

   task automatic meas(input logic [7:0] p);
      i_pwr = p; i_pwr_val = 1'b1;
      @(negedge i_clk);
      i_pwr_val = 1'b0;
   endtask

   // one full centre/up/down dither round on interior codes
   task automatic round(input logic [7:0] pc, input logic [7:0] pu, input logic [7:0] pd,
                        output logic [7:0] cc, output logic [7:0] cu, output logic [7:0] cd,
                        output bit ok);
      bit o1, o2, o3;
      wait_req(cc, o1); if (o1) begin ack; meas(pc); end
      wait_req(cu, o2); if (o2) begin ack; meas(pu); end
      wait_req(cd, o3); if (o3) begin ack; meas(pd); end
      ok = o1 && o2 && o3;
   endtask

   task automatic test_reset;
      bit ok;
      logic [7:0] code;
      i_rst = 1'b0; i_lock_en = 1'b1;
      #1;
      total++; if (o_peaks_rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy got %0b want 0", o_peaks_rdy); end
      total++; if (o_mon_state !== IDLE) begin bad++; $display("FAIL rst_state got %0d want %0d", o_mon_state, IDLE); end
      total++; if ({o_ring_tune_val, o_locked, o_fail} !== 3'b000) begin bad++; $display("FAIL rst_flags got %b want 000", {o_ring_tune_val, o_locked, o_fail}); end
      total++; if ({o_ring_tune, o_lock_code} !== 16'd0) begin bad++; $display("FAIL rst_codes got %h want 0", {o_ring_tune, o_lock_code}); end
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      total++; if (o_peaks_rdy !== 1'b1) begin bad++; $display("FAIL rdy_after_rst got %0b want 1", o_peaks_rdy); end
      @(negedge i_clk);
      // reset while a tune request is pending drops it asynchronously
      tune_pk = '{8'd11, 8'd22, 8'd33, 8'd44};
      pwr_pk  = '{8'd10, 8'd40, 8'd30, 8'd0};
      send_table(2'd2, 1'b0, 2'd0, ok);
      wait_req(code, ok);
      total++; if (!ok || code !== 8'd22) begin bad++; $display("FAIL rst_pre_req got ok=%0b code=%0d want ok=1 code=22", ok, code); end
      #2 i_rst = 1'b0;
      #1;
      total++; if (o_ring_tune_val !== 1'b0 || o_mon_state !== IDLE) begin bad++; $display("FAIL rst_mid got val=%0b st=%0d want val=0 st=0", o_ring_tune_val, o_mon_state); end
      total++; if (o_lock_code !== 8'd0) begin bad++; $display("FAIL rst_mid_code got %0d want 0", o_lock_code); end
      @(negedge i_clk);
      i_lock_en = 1'b0; i_rst = 1'b1;
      @(negedge i_clk);
   endtask

   task automatic test_select;
      bit ok;
      logic [7:0] code, want;
      logic [1:0] cnt, idx;
      logic       mode;
      do_reset;
      tune_pk = '{8'd11, 8'd22, 8'd33, 8'd44};
      for (int t = 0; t < 4; t++) begin
         case (t)
            0: begin pwr_pk = '{8'd10, 8'd40, 8'd30, 8'd0};  cnt = 2'd2; mode = 1'b0; idx = 2'd0; want = 8'd22; end
            1: begin pwr_pk = '{8'd40, 8'd40, 8'd30, 8'd0};  cnt = 2'd3; mode = 1'b0; idx = 2'd0; want = 8'd11; end
            2: begin pwr_pk = '{8'd10, 8'd20, 8'd30, 8'd90}; cnt = 2'd2; mode = 1'b0; idx = 2'd0; want = 8'd33; end
            default: begin pwr_pk = '{8'd10, 8'd20, 8'd30, 8'd90}; cnt = 2'd3; mode = 1'b1; idx = 2'd1; want = 8'd22; end
         endcase
         send_table(cnt, mode, idx, ok);
         total++; if (!ok) begin bad++; $display("FAIL sel_handshake case=%0d got ok=0 want 1", t); end
         wait_req(code, ok);
         total++; if (!ok || code !== want || o_mon_state !== APPLY_C) begin
            bad++; $display("FAIL sel_code case=%0d got ok=%0b code=%0d st=%0d want code=%0d st=%0d", t, ok, code, o_mon_state, want, APPLY_C);
         end
         i_lock_en = 1'b0;
         @(negedge i_clk);
      end
   endtask

   task automatic test_fail;
      bit ok;
      int reqs;
      logic [1:0] cnt;
      do_reset;
      tune_pk = '{8'd11, 8'd22, 8'd33, 8'd44};
      for (int t = 0; t < 3; t++) begin
         case (t)
            0: begin pwr_pk = '{8'd10, 8'd40, 8'd30, 8'd0}; cnt = 2'd2; send_table(cnt, 1'b1, 2'd3, ok); end
            1: begin pwr_pk = '{8'd10, 8'd40, 8'd30, 8'd0}; cnt = 2'd3; send_table(cnt, 1'b1, 2'd3, ok); end
            default: begin pwr_pk = '{8'd0, 8'd40, 8'd30, 8'd0}; cnt = 2'd0; send_table(cnt, 1'b0, 2'd0, ok); end
         endcase
         reqs = 0;
         for (int k = 0; k < 5; k++) begin
            if (o_ring_tune_val === 1'b1) reqs++;
            @(negedge i_clk);
         end
         total++; if (o_mon_state !== FAIL || o_fail !== 1'b1) begin bad++; $display("FAIL fail_state case=%0d got st=%0d fail=%0b want st=%0d fail=1", t, o_mon_state, o_fail, FAIL); end
         total++; if (reqs !== 0) begin bad++; $display("FAIL fail_noreq case=%0d got %0d want 0", t, reqs); end
         i_lock_en = 1'b0;
         @(negedge i_clk);
         total++; if (o_mon_state !== IDLE || o_fail !== 1'b0) begin bad++; $display("FAIL fail_exit case=%0d got st=%0d fail=%0b want st=0 fail=0", t, o_mon_state, o_fail); end
      end
   endtask

   task automatic test_track;
      bit ok;
      logic [7:0] cc, cu, cd;
      do_reset;
      tune_pk = '{8'd100, 8'd5, 8'd6, 8'd7};
      pwr_pk  = '{8'd80, 8'd0, 8'd0, 8'd0};
      send_table(2'd0, 1'b0, 2'd0, ok);
      round(8'd50, 8'd60, 8'd40, cc, cu, cd, ok);
      total++; if (!ok || {cc, cu, cd} !== {8'd100, 8'd101, 8'd99}) begin bad++; $display("FAIL track_r0 got %0d/%0d/%0d want 100/101/99", cc, cu, cd); end
      @(negedge i_clk);
      total++; if (o_lock_code !== 8'd101 || o_locked !== 1'b0) begin bad++; $display("FAIL track_move got code=%0d lk=%0b want 101/0", o_lock_code, o_locked); end
      for (int r = 1; r <= 4; r++) begin
         round(8'd50, 8'd40, 8'd30, cc, cu, cd, ok);
         total++; if (!ok || {cc, cu, cd} !== {8'd101, 8'd102, 8'd100}) begin bad++; $display("FAIL track_r%0d got %0d/%0d/%0d want 101/102/100", r, cc, cu, cd); end
         @(negedge i_clk);
         total++; if (o_locked !== (r == 4)) begin bad++; $display("FAIL track_lock_r%0d got %0b want %0b", r, o_locked, (r == 4)); end
      end
      total++; if (o_lock_code !== 8'd101) begin bad++; $display("FAIL track_lock_code got %0d want 101", o_lock_code); end
      wait_req(cc, ok);
      if (ok) begin ack; meas(8'd39); end
`ifdef TUNER_LOCK_LOSS_DETECT_EN
      total++; if (o_mon_state !== FAIL || o_locked !== 1'b0 || o_fail !== 1'b1) begin
         bad++; $display("FAIL loss_detect got st=%0d lk=%0b fail=%0b want st=%0d lk=0 fail=1", o_mon_state, o_locked, o_fail, FAIL);
      end
`else
      total++; if (o_mon_state !== APPLY_U || o_locked !== 1'b1) begin
         bad++; $display("FAIL no_loss got st=%0d lk=%0b want st=%0d lk=1", o_mon_state, o_locked, APPLY_U);
      end
      wait_req(cu, ok); if (ok) begin ack; meas(8'd20); end
      wait_req(cd, ok); if (ok) begin ack; meas(8'd10); end
      @(negedge i_clk);
      total++; if (o_locked !== 1'b1 || o_lock_code !== 8'd101) begin bad++; $display("FAIL still_locked got lk=%0b code=%0d want 1/101", o_locked, o_lock_code); end
`endif
      i_lock_en = 1'b0;
      @(negedge i_clk);
      total++; if (o_locked !== 1'b0 || o_mon_state !== IDLE) begin bad++; $display("FAIL track_disable got lk=%0b st=%0d want 0/0", o_locked, o_mon_state); end
   endtask

   task automatic test_edges;
      bit ok;
      logic [7:0] code;
      do_reset;
      tune_pk = '{8'd0, 8'd5, 8'd6, 8'd7};
      pwr_pk  = '{8'd20, 8'd0, 8'd0, 8'd0};
      send_table(2'd0, 1'b0, 2'd0, ok);
      wait_req(code, ok);
      total++; if (!ok || code !== 8'd0) begin bad++; $display("FAIL zero_c got %0d want 0", code); end
      ack; meas(8'd20);
      wait_req(code, ok);
      total++; if (!ok || code !== 8'd1) begin bad++; $display("FAIL zero_u got %0d want 1", code); end
      ack; meas(8'd10);
      total++; if (o_mon_state !== DECIDE) begin bad++; $display("FAIL zero_skip_d got st=%0d want %0d", o_mon_state, DECIDE); end
      wait_req(code, ok);
      total++; if (!ok || code !== 8'd0 || o_lock_code !== 8'd0) begin bad++; $display("FAIL zero_stay got %0d/%0d want 0/0", code, o_lock_code); end
      i_lock_en = 1'b0;
      @(negedge i_clk);
      tune_pk = '{8'd255, 8'd5, 8'd6, 8'd7};
      send_table(2'd0, 1'b0, 2'd0, ok);
      wait_req(code, ok);
      total++; if (!ok || code !== 8'd255) begin bad++; $display("FAIL max_c got %0d want 255", code); end
      ack; meas(8'd20);
      total++; if (o_mon_state !== APPLY_D || o_ring_tune !== 8'd254) begin bad++; $display("FAIL max_skip_u got st=%0d code=%0d want %0d/254", o_mon_state, o_ring_tune, APPLY_D); end
      ack; meas(8'd30);
      wait_req(code, ok);
      total++; if (!ok || code !== 8'd254) begin bad++; $display("FAIL max_down got %0d want 254", code); end
      i_lock_en = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic test_stall;
      bit ok;
      int moved;
      logic [7:0] code;
      do_reset;
      tune_pk = '{8'd11, 8'd22, 8'd33, 8'd44};
      pwr_pk  = '{8'd10, 8'd40, 8'd30, 8'd0};
      send_table(2'd2, 1'b0, 2'd0, ok);
      wait_req(code, ok);
      total++; if (!ok || code !== 8'd22) begin bad++; $display("FAIL stall_req got ok=%0b code=%0d want 1/22", ok, code); end
      moved = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge i_clk);
         if (o_ring_tune !== 8'd22 || o_mon_state !== APPLY_C || o_ring_tune_val !== 1'b1) moved++;
      end
      total++; if (moved !== 0) begin bad++; $display("FAIL stall_hold got %0d changes want 0", moved); end
      i_lock_en = 1'b0;
      @(negedge i_clk);
      total++; if (o_mon_state !== IDLE || o_ring_tune_val !== 1'b0) begin bad++; $display("FAIL stall_abort got st=%0d val=%0b want 0/0", o_mon_state, o_ring_tune_val); end
   endtask

   initial begin
      test_reset;
      test_select;
      test_fail;
      test_track;
      test_edges;
      test_stall;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
